// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: the hex glyph table,
// the all-off segment pattern and the scan state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n (listed F down to 0).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a frame-synchronous
// display buffer, an anti-ghosting blank gap per digit and leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 3,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic                we,
    input  logic                blank_lz,
    output logic [6:0]          seg_n,
    output logic [DIGITS-1:0]   an_n,
    output logic                frame_done
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] disp;
    logic [CNT_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]    digit_idx;
    scan_state_t         state;
    scan_state_t         state_next;
    logic                slot_wrap;
    logic [3:0]          nibble;
    logic                all_zero;
    logic                suppress;
    logic [6:0]          glyph;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_done = slot_wrap && (digit_idx == DIGIT_LAST);

    // The CPU writes into shadow at any time; disp only follows it at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            disp   <= '0;
        end else begin
            if (we)
                shadow <= data_in;
            if (frame_done)
                disp <= shadow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_wrap) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Walk from the top digit down so all_zero means "this nibble and every higher one is 0".
    always_comb begin
        nibble   = '0;
        all_zero = 1'b1;
        suppress = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (disp[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                nibble   = disp[4*i +: 4];
                suppress = blank_lz && (i != 0) && all_zero;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex   (nibble),
        .seg_n (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= BLANK;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        an_next    = '1;
        seg_next   = SEG_OFF;
        if (slot_wrap)
            state_next = BLANK;
        else if (slot_cnt == BLANK_LAST)
            state_next = DRIVE;
        if (state == DRIVE) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (digit_idx == IDX_W'(i))
                    an_next[i] = 1'b0;
            end
            seg_next = suppress ? SEG_OFF : glyph;
        end
    end

    // Anodes and segments leave through one register stage so they always switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= SEG_OFF;
            an_n  <= '1;
        end else begin
            seg_n <= seg_next;
            an_n  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: table-driven frames through a scoreboard
// queue plus hand-written sequences for tear-free update, write collision and reset.
module tb_seg_scan_driver;

    localparam int DIGITS = 3;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        blank_lz = 1'b0;
    logic [11:0] data_in = '0;
    logic [6:0]  seg_n;
    logic [2:0]  an_n;
    logic        frame_done;

    seg_scan_driver #(
        .DIGITS       (DIGITS),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .we         (we),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct packed {
        logic [11:0]     data;
        logic            blz;
        logic [2:0][6:0] seg;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[$];
    logic [6:0] seg_ref [16];
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    int         last_fd = -1;
    int         fd_err = 0;
    int         fd_seen = 0;
    int         onehot_err = 0;

    // Background monitors: anode exclusivity and frame_done spacing on every cycle.
    always @(negedge clk) begin
        cyc++;
        if (!$isunknown(an_n) && $countones(~an_n) > 1)
            onehot_err++;
        if (rst) begin
            last_fd = -1;
        end else if (frame_done === 1'b1) begin
            if (last_fd >= 0 && (cyc - last_fd) != FRAME)
                fd_err++;
            last_fd = cyc;
            fd_seen++;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req)
            passes++;
        else
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic step();
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic push_plain(input logic [11:0] data);
        exp_t e;
        for (int d = 0; d < DIGITS; d++) begin
            e.an  = ~(3'b001 << d);
            e.seg = seg_ref[data[4*d +: 4]];
            exp_q.push_back(e);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        data_in  = v.data;
        blank_lz = v.blz;
        we       = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            e.an  = ~(3'b001 << d);
            e.seg = v.seg[d];
            exp_q.push_back(e);
        end
        step();
    endtask

    task automatic wait_frame_done();
        int n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 4 * FRAME);
        if (frame_done !== 1'b1)
            check_output("frame_done timeout", frame_done, 1);
    endtask

    // Called on the frame_done cycle; observes the whole following frame.
    task automatic check_frame(input string tag, input logic mid_we, input logic [11:0] mid_data);
        int   blanks;
        exp_t e;
        step();
        for (int d = 0; d < DIGITS; d++) begin
            blanks = 0;
            step();
            while (an_n === 3'b111 && blanks < SLOT) begin
                blanks++;
                step();
            end
            check_output($sformatf("%s d%0d blank gap", tag, d), blanks, BLANK);
            if (exp_q.size() == 0) begin
                check_output($sformatf("%s d%0d scoreboard empty", tag, d), exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_output($sformatf("%s d%0d an_n", tag, d), an_n, e.an);
                check_output($sformatf("%s d%0d seg_n", tag, d), seg_n, e.seg);
            end
            if (d == 0 && mid_we) begin
                data_in = mid_data;
                we      = 1'b1;
                push_plain(mid_data);
            end
            repeat (SLOT - BLANK - 1) step();
        end
    endtask

    task automatic reset_and_check(input string tag);
        #1 rst = 1'b1;
        #1;
        check_output({tag, " rst seg_n"}, seg_n, 7'h7F);
        check_output({tag, " rst an_n"}, an_n, 3'b111);
        check_output({tag, " rst frame_done"}, frame_done, 0);
        step();
        step();
        blank_lz = 1'b0;
        rst      = 1'b0;
        step();
        check_output({tag, " cycle1 an_n"}, an_n, 3'b111);
        step();
        check_output({tag, " cycle2 an_n"}, an_n, 3'b111);
        step();
        check_output({tag, " cycle3 an_n"}, an_n, 3'b110);
        check_output({tag, " cycle3 seg_n"}, seg_n, 7'b1000000);
    endtask

    initial begin
        logic [3:0] a, b, c;
        seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vecs.push_back('{12'h3A7, 1'b0, {7'b0110000, 7'b0001000, 7'b1111000}});
        vecs.push_back('{12'h005, 1'b1, {7'b1111111, 7'b1111111, 7'b0010010}});
        vecs.push_back('{12'h000, 1'b1, {7'b1111111, 7'b1111111, 7'b1000000}});
        vecs.push_back('{12'h050, 1'b1, {7'b1111111, 7'b0010010, 7'b1000000}});
        vecs.push_back('{12'h005, 1'b0, {7'b1000000, 7'b1000000, 7'b0010010}});
        vecs.push_back('{12'h10E, 1'b1, {7'b1111001, 7'b1000000, 7'b0000110}});
        for (int n = 0; n < 16; n++) begin
            c = 4'(n);
            b = 4'(15 - n);
            a = 4'(n + 3);
            vecs.push_back('{{a, b, c}, 1'b0, {seg_ref[a], seg_ref[b], seg_ref[c]}});
        end

        #2;
        reset_and_check("por");

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k]);
            wait_frame_done();
            check_frame($sformatf("vec%0d", k), 1'b0, 12'h000);
        end

        // Tear-free: a mid-frame write must not disturb the frame in progress.
        data_in  = 12'h3A7;
        blank_lz = 1'b0;
        we       = 1'b1;
        push_plain(12'h3A7);
        step();
        wait_frame_done();
        check_frame("tear cur", 1'b1, 12'h111);
        wait_frame_done();
        check_frame("tear next", 1'b0, 12'h000);

        // Collision: a write on the frame_done cycle misses this frame's load.
        data_in = 12'h222;
        we      = 1'b1;
        step();
        wait_frame_done();
        data_in = 12'h555;
        we      = 1'b1;
        push_plain(12'h222);
        push_plain(12'h555);
        check_frame("collide old", 1'b0, 12'h000);
        wait_frame_done();
        check_frame("collide new", 1'b0, 12'h000);

        check_output("pre-reset driving an_n", an_n, 3'b011);
        reset_and_check("midframe");

        check_output("an_n one-hot", onehot_err, 0);
        check_output("frame_done period", fd_err, 0);
        check_output("frame_done pulses seen", (fd_seen > 10) ? 1 : 0, 1);
        check_output("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got %0d cycles, required completion", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Reader end of the 12-bit display data register: accepts a write-strobed hex value and drives a time-multiplexed common-anode seven-segment display, one digit at a time.
- Sits between the CPU-side display register and the board pins.
- Provides a tear-free frame update, a blanking gap between digits against ghosting, and optional leading-zero blanking.

Parameters:
- DIGITS, 3: number of hex digits; data width is 4*DIGITS (12 by default).
- SLOT_CYCLES, 50000: clk cycles per digit slot, including the blank gap; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  4*DIGITS  hex value to display; digit 0 is [3:0].
- we  input  1  write strobe; data_in is captured on the posedge where we=1.
- blank_lz  input  1  1 = suppress leading zero digits; digit 0 is never suppressed.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  output  DIGITS  digit enables, active-low, at most one low.
- frame_done  output  1  one-cycle pulse at the end of the last digit slot.

Behaviour:
- Reset (async, rst=1):
  - shadow = 0, disp = 0, slot_cnt = 0, digit_idx = 0, state = BLANK.
  - seg_n = all 1, an_n = all 1, frame_done = 0.
- Capture:
  - we=1 loads shadow <= data_in on that edge.
  - Back-to-back we: the last write before a frame boundary wins.
- Tear-free update:
  - disp <= shadow only on the cycle frame_done is asserted, i.e. the last cycle of digit DIGITS-1.
  - disp never changes mid-frame.
  - A we on the same cycle as frame_done is lost for disp this frame; shadow takes the new value and disp picks it up at the next frame boundary.
- slot_cnt:
  - Counts 0..SLOT_CYCLES-1 and wraps.
  - On wrap, digit_idx increments; it wraps DIGITS-1 -> 0.
  - frame_done = 1 exactly on the cycle slot_cnt = SLOT_CYCLES-1 and digit_idx = DIGITS-1.
- FSM, two states:
  - BLANK, while slot_cnt < BLANK_CYCLES: an_n all 1, seg_n all 1.
  - DRIVE, for the rest of the slot: an_n[digit_idx] = 0, seg_n = decode(disp nibble digit_idx).
  - BLANK -> DRIVE when slot_cnt reaches BLANK_CYCLES; DRIVE -> BLANK on slot wrap.
- Output timing: outputs are registered and lag the internal state by 1 cycle. an_n and seg_n change on the same edge; no glitch combination is allowed.
- Decode, standard hex, active-low:
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000.
  - 4 = 7'b0011001, 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000.
  - 8 = 7'b0000000, 9 = 7'b0010000, A = 7'b0001000, b = 7'b0000011.
  - C = 7'b1000110, d = 7'b0100001, E = 7'b0000110, F = 7'b0001110.
- Leading-zero blanking: when blank_lz = 1, digit i > 0 whose nibble and all higher nibbles are 0 drives seg_n all 1 but keeps an_n asserted in DRIVE. blank_lz is sampled live.
- Reset mid-frame: outputs go dark immediately (async); the scan restarts at digit 0, slot_cnt 0, in BLANK after release.

Decomposition:
- Shared package seg_pkg:
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF = 7'b1111111;
  - the state encoding (BLANK = 1'b0, DRIVE = 1'b1).
- One natural sub-module: hex_to_seg (combinational nibble -> seg_n lookup), instantiated once on the selected nibble.
- Scan counter and FSM stay in seg_scan_driver.

Test Plan (SLOT_CYCLES = 8, BLANK_CYCLES = 2 unless noted):
- Reset: assert rst mid-DRIVE -> seg_n = 7'h7F and an_n = 3'b111 combinationally; after release, first DRIVE is digit 0 at cycle 3 (2 blank + 1 output register).
- Basic scan: we with 12'h3A7, blank_lz = 0, wait one frame -> digit0 an_n = 3'b110, seg_n = 7'b1111000; digit1 an_n = 3'b101, seg_n = 7'b0001000; digit2 an_n = 3'b011, seg_n = 7'b0110000. Exactly 2 all-off cycles precede each digit.
- Tear-free: write 12'h111 mid-frame while displaying 12'h3A7 -> remaining digits of this frame still show 3A7; the next frame shows 111. frame_done pulses once per 24 cycles.
- Write collision: we = 1 with 12'h555 on the frame_done cycle -> the next frame shows the old shadow value; the following frame shows 555.
- Leading-zero blanking: data 12'h005, blank_lz = 1 -> digits 2 and 1 seg_n = 7'h7F with anodes still stepping; digit 0 = 7'b0010010. Data 12'h000 -> digit 0 shows 7'b1000000.
- All 16 nibble values on digit 0 -> seg_n matches the table for each; an_n never has two zeros at any cycle (bench assertion).
